// File: rtl/sevenseg_display_driver.sv
// Six-digit BCD to active-low seven-segment driver with tear filtering and per-digit blink.
// Define HEX_ALPHA_EN to decode 10..15 as A,b,C,d,E,F; otherwise they show a dash.
module sevenseg_display_driver #(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_DIV     = 25000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] svsd0_digit,
    input  logic [3:0] svsd1_digit,
    input  logic [3:0] svsd2_digit,
    input  logic [3:0] svsd3_digit,
    input  logic [3:0] svsd4_digit,
    input  logic [3:0] svsd5_digit,
    input  logic       blink_en,
    input  logic [5:0] blink_mask,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       disp_update
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PRE_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        STABLE = 1'b1
    } state_t;

    state_t           state;
    logic [23:0]      raw;
    logic [23:0]      cand;
    logic [23:0]      shown;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] prescaler;
    logic             phase;
    logic [6:0]       hex_q [6];

    assign raw = {svsd5_digit, svsd4_digit, svsd3_digit,
                  svsd2_digit, svsd1_digit, svsd0_digit};

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        // NOTE: the default arm gives every code a value, so no latch or X can escape.
        case (d)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
`ifdef HEX_ALPHA_EN
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            4'hF:    return 7'h0E;
`endif
            default: return 7'h3F;
        endcase
    endfunction

    // Digit filter: a set is committed only after it has held still long enough.
    always_ff @(posedge clk_clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset_reset) begin
            state       <= SETTLE;
            cand        <= '0;
            shown       <= '0;
            valid       <= 1'b0;
            cnt         <= '0;
            disp_update <= 1'b0;
        end else begin
            disp_update <= 1'b0;
            case (state)
                STABLE: begin
                    if (raw != cand) begin
                        cand  <= raw;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (raw != cand) begin
                        cand <= raw;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE;
                        cnt   <= '0;
                        // A glitch that settles back onto the displayed value is not news.
                        if (!(valid && (cand == shown))) begin
                            shown       <= cand;
                            valid       <= 1'b1;
                            disp_update <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    // Blink phase restarts visible with a full period every time blink_en rises.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || !blink_en) begin
            prescaler <= '0;
            phase     <= 1'b0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            phase     <= ~phase;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < 6; i++) begin
            if (reset_reset || !valid || (blink_en && blink_mask[i] && phase))
                hex_q[i] <= 7'h7F;
            else
                hex_q[i] <= seg_decode(shown[4*i +: 4]);
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_sevenseg_display_driver.sv
// Directed bench for sevenseg_display_driver: filtering, glitch rejection, blink, decode, reset.
module tb_sevenseg_display_driver;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [3:0] svsd0_digit, svsd1_digit, svsd2_digit;
    logic [3:0] svsd3_digit, svsd4_digit, svsd5_digit;
    logic       blink_en;
    logic [5:0] blink_mask;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       disp_update;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [41:0] ALL_OFF = {6{7'h7F}};
    localparam logic [41:0] P123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] P123467 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h02, 7'h78};
    localparam logic [41:0] B123467 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F};
    localparam logic [41:0] ZEROS   = {6{7'h40}};
`ifdef HEX_ALPHA_EN
    localparam logic [41:0] P12B467 = {7'h79, 7'h24, 7'h03, 7'h19, 7'h02, 7'h78};
`else
    localparam logic [41:0] P12B467 = {7'h79, 7'h24, 7'h3F, 7'h19, 7'h02, 7'h78};
`endif

    sevenseg_display_driver #(
        .STABLE_CYCLES(4),
        .BLINK_DIV    (4)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .svsd0_digit(svsd0_digit),
        .svsd1_digit(svsd1_digit),
        .svsd2_digit(svsd2_digit),
        .svsd3_digit(svsd3_digit),
        .svsd4_digit(svsd4_digit),
        .svsd5_digit(svsd5_digit),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .disp_update(disp_update)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_raw(input logic [23:0] v);
        svsd0_digit = v[3:0];
        svsd1_digit = v[7:4];
        svsd2_digit = v[11:8];
        svsd3_digit = v[15:12];
        svsd4_digit = v[19:16];
        svsd5_digit = v[23:20];
    endtask

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [41:0] hex_exp, input logic upd_exp);
        check({tag, "_hex"}, {hex5, hex4, hex3, hex2, hex1, hex0}, hex_exp);
        check({tag, "_upd"}, {41'b0, disp_update}, {41'b0, upd_exp});
    endtask

    initial begin
        reset_reset = 1'b1;
        blink_en    = 1'b0;
        blink_mask  = 6'b0;
        set_raw(24'h123456);
        tick();
        tick();
        expect_out("reset", ALL_OFF, 1'b0);

        // First commit: load at edge E, shown at E+4, hex at E+5.
        reset_reset = 1'b0;
        tick();
        expect_out("load", ALL_OFF, 1'b0);
        repeat (3) begin
            tick();
            expect_out("settle", ALL_OFF, 1'b0);
        end
        tick();
        expect_out("commit", ALL_OFF, 1'b1);
        tick();
        expect_out("first_show", P123456, 1'b0);

        // One-cycle glitch back onto the displayed value.
        set_raw(24'h999999);
        tick();
        expect_out("glitch_in", P123456, 1'b0);
        set_raw(24'h123456);
        repeat (7) begin
            tick();
            expect_out("glitch_back", P123456, 1'b0);
        end

        // Digit-by-digit write: intermediate 0x123457 must never be shown.
        svsd0_digit = 4'h7;
        tick();
        expect_out("dig0", P123456, 1'b0);
        svsd1_digit = 4'h6;
        tick();
        expect_out("dig1", P123456, 1'b0);
        repeat (3) begin
            tick();
            expect_out("dig_settle", P123456, 1'b0);
        end
        tick();
        expect_out("dig_commit", P123456, 1'b1);
        repeat (2) begin
            tick();
            expect_out("dig_show", P123467, 1'b0);
        end

        // Blink on digits 0 and 1: four visible edges, four blank, repeating.
        blink_mask = 6'b000011;
        blink_en   = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            expect_out("blink", (((k / 4) % 2) == 1) ? B123467 : P123467, 1'b0);
        end
        blink_en = 1'b0;
        tick();
        expect_out("blink_off", P123467, 1'b0);

        // Code 0xB on digit 3.
        svsd3_digit = 4'hB;
        tick();
        expect_out("alpha_load", P123467, 1'b0);
        repeat (3) begin
            tick();
            expect_out("alpha_settle", P123467, 1'b0);
        end
        tick();
        expect_out("alpha_commit", P123467, 1'b1);
        tick();
        expect_out("alpha_show", P12B467, 1'b0);

        // Reset in the middle of a settle, then a clean commit afterwards.
        set_raw(24'h000000);
        tick();
        tick();
        reset_reset = 1'b1;
        tick();
        expect_out("rst_mid", ALL_OFF, 1'b0);
        tick();
        expect_out("rst_hold", ALL_OFF, 1'b0);
        reset_reset = 1'b0;
        repeat (3) begin
            tick();
            expect_out("rst_settle", ALL_OFF, 1'b0);
        end
        tick();
        expect_out("rst_commit", ALL_OFF, 1'b1);
        tick();
        expect_out("rst_show", ZEROS, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
